// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
// Shared definitions for the VGA timing controller: configuration field
// selects, reset timing values, FSM state encoding, the per-axis total limit
// and a helper that sums the four fields of one axis.
// No ports (package).
package vga_timing_pkg;

  localparam int FIELD_W    = 10;  // width of one timing field
  localparam int CNT_W      = 11;  // column/row counter width
  localparam int NUM_FIELDS = 8;

  // Configuration field selects (i_Cfg_Sel encoding)
  localparam logic [2:0] SEL_H_ACTIVE = 3'd0;
  localparam logic [2:0] SEL_H_FP     = 3'd1;
  localparam logic [2:0] SEL_H_SYNC   = 3'd2;
  localparam logic [2:0] SEL_H_BP     = 3'd3;
  localparam logic [2:0] SEL_V_ACTIVE = 3'd4;
  localparam logic [2:0] SEL_V_FP     = 3'd5;
  localparam logic [2:0] SEL_V_SYNC   = 3'd6;
  localparam logic [2:0] SEL_V_BP     = 3'd7;

  // Reset timing (640x480 style)
  localparam int H_ACTIVE_DEFAULT = 640;
  localparam int H_FP_DEFAULT     = 18;
  localparam int H_SYNC_DEFAULT   = 92;
  localparam int H_BP_DEFAULT     = 50;
  localparam int V_ACTIVE_DEFAULT = 480;
  localparam int V_FP_DEFAULT     = 10;
  localparam int V_SYNC_DEFAULT   = 2;
  localparam int V_BP_DEFAULT     = 33;

  // Largest H_TOTAL / V_TOTAL a committed set may have. Kept one bit wider
  // than the counters so an oversize sum is never hidden by wrap-around.
  localparam logic [CNT_W:0] TOTAL_LIMIT = 12'd1024;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  typedef logic [FIELD_W-1:0] field_t;
  typedef logic [CNT_W-1:0]   cnt_t;

  // Sum of the four fields of one axis, without overflow.
  function automatic logic [CNT_W:0] axis_total(input field_t act, input field_t fp,
                                                input field_t sync, input field_t bp);
    return {2'b00, act} + {2'b00, fp} + {2'b00, sync} + {2'b00, bp};
  endfunction

endpackage

// File: rtl/vga_timing_ctrl_if.sv
// vga_timing_ctrl_if
// Control/config inputs and timing outputs of vga_timing_ctrl.
//   i_Enable      run request
//   i_Cfg_Wr      shadow field write strobe, i_Cfg_Sel selects, i_Cfg_Data value
//   i_Cfg_Commit  request to apply the shadow set
//   o_H_Sync/o_V_Sync  active-low syncs, o_Active visible pixel
//   o_Col/o_Row   current position, o_Frame_Start pulse at (0,0)
//   o_Cfg_Pending commit waiting, o_Cfg_Err commit rejected, o_Busy not idle
// Modports: master drives the inputs (host/bench), slave is the controller.
interface vga_timing_ctrl_if;
  import vga_timing_pkg::*;

  logic       i_Enable;
  logic       i_Cfg_Wr;
  logic [2:0] i_Cfg_Sel;
  field_t     i_Cfg_Data;
  logic       i_Cfg_Commit;
  logic       o_H_Sync;
  logic       o_V_Sync;
  logic       o_Active;
  cnt_t       o_Col;
  cnt_t       o_Row;
  logic       o_Frame_Start;
  logic       o_Cfg_Pending;
  logic       o_Cfg_Err;
  logic       o_Busy;

  modport master (
    output i_Enable, i_Cfg_Wr, i_Cfg_Sel, i_Cfg_Data, i_Cfg_Commit,
    input  o_H_Sync, o_V_Sync, o_Active, o_Col, o_Row, o_Frame_Start,
           o_Cfg_Pending, o_Cfg_Err, o_Busy
  );

  modport slave (
    input  i_Enable, i_Cfg_Wr, i_Cfg_Sel, i_Cfg_Data, i_Cfg_Commit,
    output o_H_Sync, o_V_Sync, o_Active, o_Col, o_Row, o_Frame_Start,
           o_Cfg_Pending, o_Cfg_Err, o_Busy
  );
endinterface

// File: rtl/vga_axis_counter.sv
// vga_axis_counter
// One timing axis (horizontal or vertical): position counter plus registered
// sync decode. The decode is done on the *next* count with the timing set that
// will be in force next cycle, so count and sync leave the flops together.
//   CLK, rst     clock, asynchronous active-high reset
//   step         advance the counter this cycle
//   show         next cycle is a scanning cycle (otherwise sync idles high)
//   cur_total    axis total of the set in force now (wrap point)
//   nxt_active/nxt_fp/nxt_sync  set in force next cycle (decode)
//   count        registered position;  count_nxt  value loaded at next edge
//   last         count is at cur_total-1
//   active_nxt   next position lies in the active region (for top to register)
//   sync_n       registered active-low sync
module vga_axis_counter
  import vga_timing_pkg::*;
(
  input  logic CLK,
  input  logic rst,
  input  logic step,
  input  logic show,
  input  cnt_t cur_total,
  input  cnt_t nxt_active,
  input  cnt_t nxt_fp,
  input  cnt_t nxt_sync,
  output cnt_t count,
  output cnt_t count_nxt,
  output logic last,
  output logic active_nxt,
  output logic sync_n
);

  cnt_t count_reg;
  logic sync_n_reg;
  logic sync_n_next;
  cnt_t sync_start;
  cnt_t sync_end;

  assign last = (count_reg == cur_total - 11'd1);

  always_comb begin
    count_nxt = count_reg;
    if (step) begin
      count_nxt = last ? '0 : count_reg + 11'd1;
    end
  end

  assign sync_start  = nxt_active + nxt_fp;
  assign sync_end    = sync_start + nxt_sync;
  assign active_nxt  = show && (count_nxt < nxt_active);
  assign sync_n_next = !(show && (count_nxt >= sync_start) && (count_nxt < sync_end));

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      count_reg  <= '0;
      sync_n_reg <= 1'b1;
    end else begin
      count_reg  <= count_nxt;
      sync_n_reg <= sync_n_next;
    end
  end

  assign count  = count_reg;
  assign sync_n = sync_n_reg;

endmodule

// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl
// Programmable VGA timing generator with double-buffered configuration.
// Writes land in a shadow set; a commit copies the shadow set into the active
// set at a frame boundary (or straight away when idle) after a sanity check.
//   CLK    sole clock, rising edge
//   i_Rst  asynchronous active-high reset
//   bus    vga_timing_ctrl_if.slave: enable, config write/commit, timing outputs
module vga_timing_ctrl
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE_DEF = H_ACTIVE_DEFAULT,
  parameter int H_FP_DEF     = H_FP_DEFAULT,
  parameter int H_SYNC_DEF   = H_SYNC_DEFAULT,
  parameter int H_BP_DEF     = H_BP_DEFAULT,
  parameter int V_ACTIVE_DEF = V_ACTIVE_DEFAULT,
  parameter int V_FP_DEF     = V_FP_DEFAULT,
  parameter int V_SYNC_DEF   = V_SYNC_DEFAULT,
  parameter int V_BP_DEF     = V_BP_DEFAULT
) (
  input  logic CLK,
  input  logic i_Rst,
  vga_timing_ctrl_if.slave bus
);

  function automatic field_t def_field(input logic [2:0] sel);
    case (sel)
      SEL_H_ACTIVE: def_field = field_t'(H_ACTIVE_DEF);
      SEL_H_FP:     def_field = field_t'(H_FP_DEF);
      SEL_H_SYNC:   def_field = field_t'(H_SYNC_DEF);
      SEL_H_BP:     def_field = field_t'(H_BP_DEF);
      SEL_V_ACTIVE: def_field = field_t'(V_ACTIVE_DEF);
      SEL_V_FP:     def_field = field_t'(V_FP_DEF);
      SEL_V_SYNC:   def_field = field_t'(V_SYNC_DEF);
      default:      def_field = field_t'(V_BP_DEF);
    endcase
  endfunction

  state_t state_reg, state_next;
  logic   pending_reg, pending_next;
  logic   err_reg, err_next;
  logic   busy_reg, busy_next;
  logic   active_reg, active_next;
  logic   frame_start_reg, frame_start_next;

  field_t shadow_set  [NUM_FIELDS];
  field_t timing_set  [NUM_FIELDS];
  field_t timing_next [NUM_FIELDS];

  logic             busy_now, frame_end, apply_now, apply_ok, shadow_valid;
  logic [CNT_W:0]   shadow_htot, shadow_vtot;
  cnt_t             cur_htot, cur_vtot;
  cnt_t             h_count, v_count, h_count_nxt, v_count_nxt;
  logic             h_last, v_last, h_active_nxt, v_active_nxt, h_sync_n, v_sync_n;

  // Shadow and active copies of each timing field. The active copy takes the
  // shadow value only on an accepted apply; a write in the apply cycle lands
  // in the shadow one edge later and so misses that apply.
  generate
    for (genvar gi = 0; gi < NUM_FIELDS; gi++) begin : g_field
      field_t shadow_reg;
      field_t timing_reg;

      always_ff @(posedge CLK or posedge i_Rst) begin
        if (i_Rst) begin
          shadow_reg <= def_field(3'(gi));
          timing_reg <= def_field(3'(gi));
        end else begin
          if (bus.i_Cfg_Wr && (bus.i_Cfg_Sel == 3'(gi))) begin
            shadow_reg <= bus.i_Cfg_Data;
          end
          timing_reg <= timing_next[gi];
        end
      end

      assign shadow_set[gi]  = shadow_reg;
      assign timing_set[gi]  = timing_reg;
      assign timing_next[gi] = apply_ok ? shadow_reg : timing_reg;
    end
  endgenerate

  assign shadow_htot = axis_total(shadow_set[SEL_H_ACTIVE], shadow_set[SEL_H_FP],
                                  shadow_set[SEL_H_SYNC], shadow_set[SEL_H_BP]);
  assign shadow_vtot = axis_total(shadow_set[SEL_V_ACTIVE], shadow_set[SEL_V_FP],
                                  shadow_set[SEL_V_SYNC], shadow_set[SEL_V_BP]);
  assign shadow_valid = (shadow_set[SEL_H_ACTIVE] != '0) && (shadow_set[SEL_H_SYNC] != '0) &&
                        (shadow_set[SEL_V_ACTIVE] != '0) && (shadow_set[SEL_V_SYNC] != '0) &&
                        (shadow_htot <= TOTAL_LIMIT) && (shadow_vtot <= TOTAL_LIMIT);

  // The active set was validated on entry, so its totals fit the counters.
  assign cur_htot = cnt_t'(axis_total(timing_set[SEL_H_ACTIVE], timing_set[SEL_H_FP],
                                      timing_set[SEL_H_SYNC], timing_set[SEL_H_BP]));
  assign cur_vtot = cnt_t'(axis_total(timing_set[SEL_V_ACTIVE], timing_set[SEL_V_FP],
                                      timing_set[SEL_V_SYNC], timing_set[SEL_V_BP]));

  assign busy_now  = (state_reg != ST_IDLE);
  assign frame_end = busy_now && h_last && v_last;
  assign apply_now = pending_reg && ((state_reg == ST_IDLE) || frame_end);
  assign apply_ok  = apply_now && shadow_valid;

  always_comb begin
    state_next       = state_reg;
    pending_next     = pending_reg;
    err_next         = 1'b0;
    busy_next        = 1'b0;
    active_next      = 1'b0;
    frame_start_next = 1'b0;

    case (state_reg)
      ST_IDLE:  if (bus.i_Enable) state_next = ST_RUN;
      ST_RUN:   if (!bus.i_Enable) state_next = ST_DRAIN;
      ST_DRAIN: begin
        if (bus.i_Enable)   state_next = ST_RUN;
        else if (frame_end) state_next = ST_IDLE;
      end
      default:  state_next = ST_IDLE;
    endcase

    // A commit arriving while one is already pending is dropped silently.
    if (apply_now) begin
      pending_next = 1'b0;
      err_next     = !shadow_valid;
    end else if (bus.i_Cfg_Commit) begin
      pending_next = 1'b1;
    end

    busy_next        = (state_next != ST_IDLE);
    active_next      = h_active_nxt && v_active_nxt;
    frame_start_next = busy_next && (h_count_nxt == '0) && (v_count_nxt == '0);
  end

  always_ff @(posedge CLK or posedge i_Rst) begin
    if (i_Rst) begin
      state_reg       <= ST_IDLE;
      pending_reg     <= 1'b0;
      err_reg         <= 1'b0;
      busy_reg        <= 1'b0;
      active_reg      <= 1'b0;
      frame_start_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      pending_reg     <= pending_next;
      err_reg         <= err_next;
      busy_reg        <= busy_next;
      active_reg      <= active_next;
      frame_start_reg <= frame_start_next;
    end
  end

  // Counters hold at 0 in IDLE (step low) so the first RUN cycle shows (0,0).
  vga_axis_counter u_h_axis (
    .CLK        (CLK),
    .rst        (i_Rst),
    .step       (busy_now),
    .show       (busy_next),
    .cur_total  (cur_htot),
    .nxt_active ({1'b0, timing_next[SEL_H_ACTIVE]}),
    .nxt_fp     ({1'b0, timing_next[SEL_H_FP]}),
    .nxt_sync   ({1'b0, timing_next[SEL_H_SYNC]}),
    .count      (h_count),
    .count_nxt  (h_count_nxt),
    .last       (h_last),
    .active_nxt (h_active_nxt),
    .sync_n     (h_sync_n)
  );

  vga_axis_counter u_v_axis (
    .CLK        (CLK),
    .rst        (i_Rst),
    .step       (busy_now && h_last),
    .show       (busy_next),
    .cur_total  (cur_vtot),
    .nxt_active ({1'b0, timing_next[SEL_V_ACTIVE]}),
    .nxt_fp     ({1'b0, timing_next[SEL_V_FP]}),
    .nxt_sync   ({1'b0, timing_next[SEL_V_SYNC]}),
    .count      (v_count),
    .count_nxt  (v_count_nxt),
    .last       (v_last),
    .active_nxt (v_active_nxt),
    .sync_n     (v_sync_n)
  );

  assign bus.o_H_Sync      = h_sync_n;
  assign bus.o_V_Sync      = v_sync_n;
  assign bus.o_Active      = active_reg;
  assign bus.o_Col         = h_count;
  assign bus.o_Row         = v_count;
  assign bus.o_Frame_Start = frame_start_reg;
  assign bus.o_Cfg_Pending = pending_reg;
  assign bus.o_Cfg_Err     = err_reg;
  assign bus.o_Busy        = busy_reg;

endmodule

// File: doc/vga_timing_ctrl.md
VGA_TIMING_CTRL -- requirements
Module: vga_timing_ctrl

Interface
REQ-001 SHALL have parameter H_ACTIVE_DEF, 640, reset active width in pixels.
REQ-002 SHALL have parameters H_FP_DEF 18, H_SYNC_DEF 92, H_BP_DEF 50: reset horizontal front porch, pulse and back porch.
REQ-003 SHALL have parameters V_ACTIVE_DEF 480, V_FP_DEF 10, V_SYNC_DEF 2, V_BP_DEF 33: reset vertical timing in lines.
REQ-004 SHALL have ports:
  CLK  in  1  sole clock, rising edge
  i_Rst  in  1  asynchronous, active-high reset
  i_Enable  in  1  run request
  i_Cfg_Wr  in  1  shadow-register write strobe
  i_Cfg_Sel  in  3  field: 0 H_ACTIVE, 1 H_FP, 2 H_SYNC, 3 H_BP, 4 V_ACTIVE, 5 V_FP, 6 V_SYNC, 7 V_BP
  i_Cfg_Data  in  10  field value
  i_Cfg_Commit  in  1  request to apply shadow set
  o_H_Sync  out  1  horizontal sync, active low
  o_V_Sync  out  1  vertical sync, active low
  o_Active  out  1  visible-pixel flag
  o_Col  out  11  current column
  o_Row  out  11  current row
  o_Frame_Start  out  1  one-cycle pulse at col 0, row 0
  o_Cfg_Pending  out  1  commit waiting for frame boundary
  o_Cfg_Err  out  1  one-cycle pulse, commit rejected
  o_Busy  out  1  state is not IDLE

Function
REQ-005 SHALL implement states IDLE, RUN, DRAIN.
REQ-006 IDLE: o_Col = o_Row = 0, syncs 1, o_Active 0; i_Enable=1 moves to RUN.
REQ-007 First RUN cycle SHALL present col 0, row 0 with o_Frame_Start=1.
REQ-008 In RUN/DRAIN, col SHALL increment each cycle and wrap to 0 at H_TOTAL-1; row SHALL increment on column wrap and wrap to 0 at V_TOTAL-1. H_TOTAL = sum of four H fields; V likewise; 11-bit arithmetic.
REQ-009 Per-axis order SHALL be active, front porch, sync, back porch. o_H_Sync=0 iff H_ACTIVE+H_FP <= col < H_ACTIVE+H_FP+H_SYNC. V_Sync uses the same rule on row.
REQ-010 o_Active SHALL be 1 iff col < H_ACTIVE and row < V_ACTIVE.
REQ-011 All outputs SHALL be registered and describe the col/row shown in the same cycle; zero skew between them.
REQ-012 i_Enable=0 in RUN SHALL move to DRAIN. The current frame then completes, and the FSM enters IDLE after the cycle at col H_TOTAL-1, row V_TOTAL-1. i_Enable=1 in DRAIN SHALL return to RUN with no timing break.
REQ-013 i_Cfg_Wr SHALL update the selected shadow field next cycle; active timing SHALL be unaffected.
REQ-014 i_Cfg_Commit SHALL set o_Cfg_Pending. Apply point: in IDLE, the next cycle; otherwise, after the last pixel of the frame. At the apply point, shadow SHALL be copied to active timing and Pending cleared.
REQ-015 A write in the same cycle as the apply point SHALL NOT be included in that apply. A write while Pending SHALL be included.
REQ-016 At apply, if any ACTIVE or SYNC field is 0, or H_TOTAL or V_TOTAL > 1024: the active set SHALL be unchanged, o_Cfg_Err SHALL pulse, and Pending SHALL clear.
REQ-017 A commit while Pending SHALL be ignored (no error).
REQ-018 The first frame after an apply SHALL use the new timing from col 0, row 0.

Reset
REQ-019 i_Rst SHALL asynchronously force IDLE and load both active and shadow sets from the *_DEF parameters.
REQ-020 i_Rst SHALL force col/row 0, syncs 1, and all other outputs 0.
REQ-021 Reset mid-frame SHALL abandon the frame and any pending commit. The first cycle after release SHALL be IDLE.

Structure
REQ-022 Package vga_timing_pkg SHALL hold the field-select constants, the default timing values, the state encoding and the 1024 limit.
REQ-023 Per-axis counting and sync/active decode SHALL be sub-module vga_axis_counter, instantiated once for H and once for V.

Verification
REQ-024 Reset, enable with defaults -> H_Sync low cols 658-749; V_Sync low rows 490-491; Active 640x480; Frame_Start every 420000 cycles.
REQ-025 Write H_ACTIVE=320, H_FP=8, H_SYNC=48, H_BP=24, then commit mid-frame -> Pending=1 until the frame ends; the next frame has H_TOTAL 400 and H_Sync low at cols 328-375.
REQ-026 Commit with V_SYNC=0 -> Err pulses one cycle at the frame end; timing unchanged; Pending=0.
REQ-027 Drop i_Enable at row 100 -> frame completes to row 524, col 799; then IDLE, Busy=0. Re-enable at row 300 during DRAIN -> no break.
REQ-028 Assert i_Rst at col 700 (H_Sync low) -> syncs 1 and col/row 0 immediately, before the clock edge.
REQ-029 Commit in IDLE, then enable -> the first frame uses the new timing.
